rr_onehot_arbiter: RTL



---
 rtl/rr_onehot_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/rr_onehot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_onehot_arbiter
// Brief    : Registered round-robin arbiter with a valid/ready grant handshake
//            and an optional grant lock bounded by MAX_LOCK consecutive grants.
//            Priority runs from the highest index downward, starting just
//            below the last winner, then wraps.
// Revision : 1.0 - initial release
// ============================================================================
module rr_onehot_arbiter #(
  parameter int N        = 8,
  parameter int MAX_LOCK = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 lock,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_valid,
  input  logic                 gnt_ready
);

  localparam int C_IW = $clog2(N);
  // Lock counter only needs to reach MAX_LOCK-1; keep at least one bit.
  localparam int C_LW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
  localparam logic [C_LW-1:0] C_LOCK_LAST = C_LW'(MAX_LOCK - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [N-1:0]    r_gnt;
  logic [N-1:0]    w_gnt_nxt;
  logic [C_IW-1:0] r_idx;
  logic [C_IW-1:0] w_idx_nxt;
  logic [N-1:0]    r_last;
  logic [N-1:0]    w_last_nxt;
  logic [C_LW-1:0] r_lock_cnt;
  logic [C_LW-1:0] w_lock_cnt_nxt;

  logic            w_hs;
  logic            w_regrant;
  logic [N-1:0]    w_last_eff;
  logic [N-1:0]    w_mask;
  logic [N-1:0]    w_req_m;
  logic [N-1:0]    w_win;
  logic [C_IW-1:0] w_win_idx;

  // Highest set bit as one-hot: reversed prefix-OR, then edge detect.
  function automatic logic [N-1:0] f_highest(input logic [N-1:0] x);
    logic [N-1:0] pre;
    logic [N-1:0] y;
    pre[N-1] = x[N-1];
    for (int i = N - 2; i >= 0; i--) begin
      pre[i] = x[i] | pre[i+1];
    end
    y[N-1] = pre[N-1];
    for (int i = 0; i < N - 1; i++) begin
      y[i] = pre[i] & ~pre[i+1];
    end
    return y;
  endfunction

  // One-hot to binary; zero input gives zero.
  function automatic logic [C_IW-1:0] f_encode(input logic [N-1:0] x);
    logic [C_IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (x[i]) begin
        idx = idx | C_IW'(i);
      end
    end
    return idx;
  endfunction

  assign w_hs      = (r_state == S_GRANT) && gnt_ready;
  assign w_regrant = w_hs && lock && req[r_idx] && (r_lock_cnt < C_LOCK_LAST);

  // On a handshake the grant being retired becomes the pointer this same
  // cycle, so the next winner is chosen without a bubble.
  assign w_last_eff = w_hs ? r_gnt : r_last;
  assign w_mask     = (w_last_eff == '0) ? '1 : (w_last_eff - N'(1));
  assign w_req_m    = req & w_mask;
  assign w_win      = (|w_req_m) ? f_highest(w_req_m) : f_highest(req);
  assign w_win_idx  = f_encode(w_win);

  // Next-state, next-grant, pointer and lock-counter decisions.
  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_idx_nxt      = r_idx;
    w_last_nxt     = r_last;
    w_lock_cnt_nxt = r_lock_cnt;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_gnt_nxt   = w_win;
          w_idx_nxt   = w_win_idx;
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        if (w_regrant) begin
          // Same requester again; pointer stays put.
          w_lock_cnt_nxt = r_lock_cnt + C_LW'(1);
        end else if (w_hs) begin
          w_last_nxt     = r_gnt;
          w_lock_cnt_nxt = '0;
          if (|req) begin
            w_gnt_nxt = w_win;
            w_idx_nxt = w_win_idx;
          end else begin
            w_gnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // State and grant registers; reset drops any pending grant at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_gnt      <= '0;
      r_idx      <= '0;
      r_last     <= '0;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_idx      <= w_idx_nxt;
      r_last     <= w_last_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_idx;
  assign gnt_valid = (r_state == S_GRANT);

endmodule
`default_nettype wire
